// File: rtl/gate_step_guard.sv
// Gate-pattern register for the commutation FSM. Holds each applied pattern for a
// minimum dwell time and faults on requests that change more than one switch per step.
module gate_step_guard #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STEP_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        sw_req,
  input  logic              fault_clr,
  output logic [5:0]        gate_out,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [STEP_W-1:0] step_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  localparam logic [1:0]       CODE_NONE    = 2'b00;
  localparam logic [1:0]       CODE_COUNT   = 2'b01;
  localparam logic [1:0]       CODE_STEP    = 2'b10;
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [5:0]        gate_q, gate_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic [1:0]        code_q, code_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [5:0]        diff;

  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      gate_q  <= '0;
      dcnt_q  <= '0;
      code_q  <= CODE_NONE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      dcnt_q  <= dcnt_d;
      code_q  <= code_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    dcnt_d  = dcnt_q;
    code_d  = code_q;
    step_d  = step_q;
    diff    = sw_req ^ gate_q;
    case (state_q)
      ST_RUN: begin
        if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - CNT_W'(1);
        end else if (diff != '0) begin
          // Safe-off is checked first so it is accepted regardless of step size
          if ((sw_req == '0) ||
              ((popcnt6(sw_req) <= 3'd2) &&
               ((gate_q == '0) || (popcnt6(diff) == 3'd1)))) begin
            gate_d = sw_req;
            dcnt_d = DWELL_RELOAD;
            step_d = step_q + STEP_W'(1);
          end else begin
            state_d = ST_FAULT;
            gate_d  = '0;
            dcnt_d  = '0;
            code_d  = (popcnt6(sw_req) > 3'd2) ? CODE_COUNT : CODE_STEP;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr && (sw_req == '0)) begin
          state_d = ST_RUN;
          code_d  = CODE_NONE;
          dcnt_d  = DWELL_RELOAD;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign gate_out   = gate_q;
  assign busy       = (dcnt_q != '0) && (state_q == ST_RUN);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;
  assign step_cnt   = step_q;

endmodule

// File: tb/tb_gate_step_guard.sv
// Scenario bench for gate_step_guard: DWELL=4 with a 4-bit step counter (exercises wrap),
// plus a DWELL=1 instance. Expected outputs are queued per driven cycle and checked after the edge.
module tb_gate_step_guard;

  logic        clk;
  logic        rst;
  logic [5:0]  sw_req;
  logic        fault_clr;
  logic [5:0]  gate_out;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;
  logic [3:0]  step_cnt;

  logic [5:0]  req1;
  logic [5:0]  gate1;
  logic        busy1;
  logic        fault1;
  logic [1:0]  code1;
  logic [15:0] step1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic [5:0]  g;
    logic        b;
    logic        f;
    logic [1:0]  c;
    logic [15:0] s;
  } exp_t;

  typedef struct {
    logic       r;
    logic [5:0] q;
    logic       c;
    exp_t       e;
  } stim_t;

  exp_t sbq[$];
  exp_t sbq1[$];

  gate_step_guard #(.DWELL_CYCLES(4), .CNT_W(8), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .fault_clr(fault_clr),
    .gate_out(gate_out), .busy(busy), .fault(fault), .fault_code(fault_code),
    .step_cnt(step_cnt)
  );

  gate_step_guard #(.DWELL_CYCLES(1), .CNT_W(4), .STEP_W(16)) dut1 (
    .clk(clk), .rst(rst), .sw_req(req1), .fault_clr(fault_clr),
    .gate_out(gate1), .busy(busy1), .fault(fault1), .fault_code(code1),
    .step_cnt(step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(logic r, logic [5:0] q, logic c, logic [5:0] g,
                               logic b, logic f, logic [1:0] cd, int unsigned s);
    stim_t x;
    x.r   = r;
    x.q   = q;
    x.c   = c;
    x.e.g = g;
    x.e.b = b;
    x.e.f = f;
    x.e.c = cd;
    x.e.s = 16'(s);
    return x;
  endfunction

  task automatic test_reset();
    stim_t t[$];
    exp_t  e, o;
    for (int i = 0; i < 3; i++) t.push_back(mk(1'b0, 6'b110000, 1'b0, 6'b000000, 1'b0, 1'b0, 2'b00, 0));
    t.push_back(mk(1'b1, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 2'b00, 0));
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_dwell();
    stim_t t[$];
    exp_t  e, o;
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b100000, 0, 6'b110000, 1, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b100000, 0, 6'b110000, 1, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b100000, 0, 6'b110000, 0, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 1, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 1, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 1, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 0, 0, 2'b00, 2));
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL dwell row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_step_fault();
    stim_t t[$];
    exp_t  e, o;
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 0, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b001100, 0, 6'b000000, 0, 1, 2'b10, 3));
    t.push_back(mk(1, 6'b111111, 0, 6'b000000, 0, 1, 2'b10, 3));
    t.push_back(mk(1, 6'b100000, 1, 6'b000000, 0, 1, 2'b10, 3));
    t.push_back(mk(1, 6'b000000, 1, 6'b000000, 1, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b100000, 0, 6'b000000, 1, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b100000, 0, 6'b000000, 1, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b100000, 0, 6'b000000, 0, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 1, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 1, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 1, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b100000, 0, 6'b100000, 0, 0, 2'b00, 4));
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL step_fault row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_count_fault();
    stim_t t[$];
    exp_t  e, o;
    t.push_back(mk(1, 6'b111000, 0, 6'b000000, 0, 1, 2'b01, 4));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 1, 2'b01, 4));
    t.push_back(mk(1, 6'b000000, 1, 6'b000000, 1, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 1, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 1, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 4));
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL count_fault row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_run_clr();
    stim_t t[$];
    exp_t  e, o;
    t.push_back(mk(1, 6'b001000, 1, 6'b001000, 1, 0, 2'b00, 5));
    t.push_back(mk(1, 6'b001000, 1, 6'b001000, 1, 0, 2'b00, 5));
    t.push_back(mk(1, 6'b001000, 1, 6'b001000, 1, 0, 2'b00, 5));
    t.push_back(mk(1, 6'b001000, 1, 6'b001000, 0, 0, 2'b00, 5));
    t.push_back(mk(1, 6'b000000, 1, 6'b000000, 1, 0, 2'b00, 6));
    t.push_back(mk(1, 6'b000000, 1, 6'b000000, 1, 0, 2'b00, 6));
    t.push_back(mk(1, 6'b000000, 1, 6'b000000, 1, 0, 2'b00, 6));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 6));
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL run_clr row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    exp_t  e, o;
    t.push_back(mk(1, 6'b101000, 0, 6'b101000, 1, 0, 2'b00, 7));
    t.push_back(mk(1, 6'b101000, 0, 6'b101000, 1, 0, 2'b00, 7));
    t.push_back(mk(0, 6'b101000, 0, 6'b000000, 0, 0, 2'b00, 0));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 0));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 1, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 0, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 1, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 1, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 1, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b111000, 0, 6'b000000, 0, 1, 2'b01, 2));
    t.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 0));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 0));
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t       t[$];
    exp_t        e, o;
    logic [5:0]  q;
    for (int k = 1; k <= 17; k++) begin
      q = (k % 2 == 1) ? 6'b000001 : 6'b000000;
      t.push_back(mk(1, q, 0, q, 1, 0, 2'b00, k % 16));
      t.push_back(mk(1, q, 0, q, 1, 0, 2'b00, k % 16));
      t.push_back(mk(1, q, 0, q, 1, 0, 2'b00, k % 16));
      t.push_back(mk(1, q, 0, q, 0, 0, 2'b00, k % 16));
    end
    foreach (t[i]) begin
      rst = t[i].r; sw_req = t[i].q; fault_clr = t[i].c;
      sbq.push_back(t[i].e);
      tick();
      e = sbq.pop_front();
      o = {gate_out, busy, fault, fault_code, 12'h000, step_cnt};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL wrap row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_dwell1();
    stim_t t[$];
    exp_t  e, o;
    sw_req = 6'b000000;
    t.push_back(mk(1, 6'b000001, 0, 6'b000001, 0, 0, 2'b00, 1));
    t.push_back(mk(1, 6'b000011, 0, 6'b000011, 0, 0, 2'b00, 2));
    t.push_back(mk(1, 6'b000010, 0, 6'b000010, 0, 0, 2'b00, 3));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 4));
    t.push_back(mk(1, 6'b110000, 0, 6'b110000, 0, 0, 2'b00, 5));
    t.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 2'b00, 6));
    t.push_back(mk(1, 6'b001100, 0, 6'b001100, 0, 0, 2'b00, 7));
    t.push_back(mk(1, 6'b001101, 0, 6'b000000, 0, 1, 2'b01, 7));
    t.push_back(mk(1, 6'b000000, 1, 6'b000000, 0, 0, 2'b00, 7));
    t.push_back(mk(1, 6'b000100, 0, 6'b000100, 0, 0, 2'b00, 8));
    foreach (t[i]) begin
      rst = t[i].r; req1 = t[i].q; fault_clr = t[i].c;
      sbq1.push_back(t[i].e);
      tick();
      e = sbq1.pop_front();
      o = {gate1, busy1, fault1, code1, step1};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL dwell1 row %0d: got g=%b busy=%b fault=%b code=%b step=%0d, want g=%b busy=%b fault=%b code=%b step=%0d",
                 i, o.g, o.b, o.f, o.c, o.s, e.g, e.b, e.f, e.c, e.s);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    sw_req    = 6'b000000;
    fault_clr = 1'b0;
    req1      = 6'b000000;
    test_reset();
    test_dwell();
    test_step_fault();
    test_count_fault();
    test_run_clr();
    test_reset_mid();
    test_wrap();
    test_dwell1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
